// File: rtl/matvec_engine.sv
// ---------------------------------------------------------------------------
// matvec_engine
//
// Drains ROWS row FIFOs (matrix A) and one vector FIFO (B) and computes the
// ROWS dot products A[i] . B using a skewed chain of multiply-accumulate
// lanes. Lane i starts reading its row one cycle after lane i-1, and B is
// delayed one register per lane, so each lane sees matching A/B elements.
//
// Ports
//   clk, rst   clock, synchronous active-high reset
//   start      single-cycle request to begin a run (needs all FIFOs non-empty)
//   a_data     row FIFO read data, lane i at [i*DW +: DW]
//   a_empty    row FIFO empty flags
//   a_rden     row FIFO read enables
//   b_data     vector FIFO read data
//   b_empty    vector FIFO empty flag
//   b_rden     vector FIFO read enable
//   busy       high during the run
//   done       one-cycle pulse once every result is final
//   err        sticky: a read was issued to an empty FIFO
//   result     lane i dot product at [i*ACCW +: ACCW]
// ---------------------------------------------------------------------------
module matvec_engine #(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int DW   = 8,
   parameter int ACCW = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ROWS*DW-1:0]   a_data,
   input  logic [ROWS-1:0]      a_empty,
   output logic [ROWS-1:0]      a_rden,
   input  logic [DW-1:0]        b_data,
   input  logic                 b_empty,
   output logic                 b_rden,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [ROWS*ACCW-1:0] result
);

   localparam int CW = $clog2(ROWS + COLS + 1);
   localparam logic [CW-1:0] LAST_CYC = CW'(ROWS + COLS - 1);
   localparam logic [CW-1:0] COLS_C   = CW'(COLS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cyc_reg, cyc_next;
   logic          run;
   logic          accept;
   logic          err_reg;

   logic [DW-1:0]   b_pipe  [ROWS];
   logic [ACCW-1:0] acc_reg [ROWS];

   assign run    = (state_reg == RUN);
   assign accept = (state_reg == IDLE) && start && !(|a_empty) && !b_empty;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cyc_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cyc_reg   <= cyc_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cyc_next   = cyc_reg;
      busy       = 1'b0;
      done       = 1'b0;
      b_rden     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = RUN;
               cyc_next   = '0;
            end
         end
         RUN: begin
            busy   = 1'b1;
            b_rden = (cyc_reg < COLS_C);
            if (cyc_reg == LAST_CYC) begin
               state_next = DONE;
               cyc_next   = '0;
            end else begin
               cyc_next = cyc_reg + 1'b1;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- underflow flag ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (accept) begin
         err_reg <= 1'b0;
      end else if ((|(a_rden & a_empty)) || (b_rden && b_empty)) begin
         err_reg <= 1'b1;
      end
   end

   assign err = err_reg;

   // ---------------- lanes ----------------
   // Window tests use (cyc - lo) < COLS: when cyc < lo the subtraction wraps
   // to a value >= 2^CW - ROWS, which always exceeds COLS because 2^CW holds
   // ROWS+COLS+1. This avoids a ">= 0" compare for lane 0.
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
      localparam logic [CW-1:0] RD_LO = CW'(gi);
      localparam logic [CW-1:0] AC_LO = CW'(gi + 1);

      logic [DW-1:0]   a_op;
      logic [2*DW-1:0] prod;
      logic            acc_en;

      // B delay line: element k is read in cycle k, valid at b_data in k+1,
      // and reaches lane i in cycle k+1+i, matching row i's read skew.
      if (gi == 0) begin : g_b0
         assign b_pipe[gi] = b_data;
      end else begin : g_bn
         logic [DW-1:0] b_stage_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               b_stage_reg <= '0;
            end else begin
               b_stage_reg <= b_pipe[gi-1];
            end
         end
         assign b_pipe[gi] = b_stage_reg;
      end

      assign a_rden[gi] = run && ((cyc_reg - RD_LO) < COLS_C);
      assign acc_en     = run && ((cyc_reg - AC_LO) < COLS_C);
      assign a_op       = a_data[gi*DW +: DW];
      assign prod       = (2*DW)'(a_op) * (2*DW)'(b_pipe[gi]);

      always_ff @(posedge clk) begin
         if (rst) begin
            acc_reg[gi] <= '0;
         end else if (accept) begin
            acc_reg[gi] <= '0;
         end else if (acc_en) begin
            acc_reg[gi] <= acc_reg[gi] + ACCW'(prod);
         end
      end

      assign result[gi*ACCW +: ACCW] = acc_reg[gi];
   end

endmodule

// File: tb/tb_matvec_engine.sv
// ---------------------------------------------------------------------------
// tb_matvec_engine
//
// Directed bench for matvec_engine. Behavioural FIFO models (one-cycle read
// latency) feed the engine; expected results are hand-computed constants.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_matvec_engine;

   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int DW   = 8;
   localparam int ACCW = 24;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [ROWS*DW-1:0]   a_data = '0;
   logic [ROWS-1:0]      a_empty;
   logic [ROWS-1:0]      a_rden;
   logic [DW-1:0]        b_data = '0;
   logic                 b_empty;
   logic                 b_rden;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [ROWS*ACCW-1:0] result;

   int total = 0;
   int bad   = 0;

   // FIFO models
   logic [DW-1:0] a_mem [ROWS][16];
   logic [DW-1:0] b_mem [16];
   int            a_wr [ROWS];
   int            a_rd [ROWS];
   int            b_wr = 0;
   int            b_rd = 0;
   logic          flush = 1'b0;

   logic [ACCW-1:0] exp_res [ROWS];

   matvec_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACCW(ACCW)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a_data  (a_data),
      .a_empty (a_empty),
      .a_rden  (a_rden),
      .b_data  (b_data),
      .b_empty (b_empty),
      .b_rden  (b_rden),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .result  (result)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < ROWS; i++) a_empty[i] = (a_wr[i] == a_rd[i]);
      b_empty = (b_wr == b_rd);
   end

   // Read from an empty FIFO leaves the data register unchanged.
   always @(posedge clk) begin
      if (flush) begin
         for (int i = 0; i < ROWS; i++) a_rd[i] <= 0;
         b_rd <= 0;
      end else begin
         for (int i = 0; i < ROWS; i++) begin
            if (a_rden[i] && (a_rd[i] != a_wr[i])) begin
               a_data[i*DW +: DW] <= a_mem[i][a_rd[i]];
               a_rd[i]            <= a_rd[i] + 1;
            end
         end
         if (b_rden && (b_rd != b_wr)) begin
            b_data <= b_mem[b_rd];
            b_rd   <= b_rd + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic int remaining();
      int s;
      s = b_wr - b_rd;
      for (int i = 0; i < ROWS; i++) s += a_wr[i] - a_rd[i];
      return s;
   endfunction

   // mode 0: A=0x01, B=1..8   mode 1: all 0xFF   mode 2: identity, B=0x11..0x18
   task automatic load(input int mode, input int short_row, input int skip_row);
      flush = 1'b1;
      for (int i = 0; i < ROWS; i++) a_wr[i] = 0;
      b_wr = 0;
      @(negedge clk);
      flush = 1'b0;
      for (int k = 0; k < COLS; k++) begin
         case (mode)
            0:       b_mem[k] = 8'(k + 1);
            1:       b_mem[k] = 8'hFF;
            default: b_mem[k] = 8'(8'h11 + k);
         endcase
         b_wr = k + 1;
         for (int i = 0; i < ROWS; i++) begin
            if (i != skip_row && !(i == short_row && k == COLS - 1)) begin
               case (mode)
                  0:       a_mem[i][k] = 8'h01;
                  1:       a_mem[i][k] = 8'hFF;
                  default: a_mem[i][k] = (i == k) ? 8'h01 : 8'h00;
               endcase
               a_wr[i] = k + 1;
            end
         end
      end
   endtask

   // Pulses start, follows the run cycle by cycle and checks timing, read
   // enables, results (lanes in lane_mask), err and FIFO drain.
   task automatic do_run(input string name, input logic [ROWS-1:0] lane_mask,
                         input logic exp_err);
      int busy_cnt = 0;
      int rden_bad = 0;
      int done_at  = -1;
      logic busy_at_done = 1'b1;
      logic [ROWS-1:0] ea;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < ROWS; i++) ea[i] = (n >= i) && (n < i + COLS);
         if (busy) busy_cnt++;
         if (a_rden !== ea || b_rden !== (n < COLS)) rden_bad++;
         if (done) begin
            done_at      = n;
            busy_at_done = busy;
            break;
         end
         @(negedge clk);
      end
      chk({name, "_done_cycle"}, 32'(done_at), 32'd16);
      chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
      chk({name, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
      chk({name, "_rden_pattern"}, 32'(rden_bad), 32'd0);
      for (int i = 0; i < ROWS; i++) begin
         if (lane_mask[i]) begin
            chk($sformatf("%s_res%0d", name, i), 32'(result[i*ACCW +: ACCW]), 32'(exp_res[i]));
         end
      end
      chk({name, "_err"}, 32'(err), 32'(exp_err));
      chk({name, "_fifos_empty"}, 32'(remaining()), 32'd0);
      @(negedge clk);
      chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
   endtask

   initial begin
      int pulses;
      logic saw_busy;
      for (int i = 0; i < ROWS; i++) begin
         a_wr[i] = 0;
         a_rd[i] = 0;
      end

      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rden", 32'({a_rden, b_rden}), 32'd0);
      chk("rst_result_or", 32'(|result), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // ones x ramp
      load(0, -1, -1);
      for (int i = 0; i < ROWS; i++) exp_res[i] = 24'h24;
      do_run("ramp", 8'hFF, 1'b0);

      // reset mid-run at cyc=5
      load(0, -1, -1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      chk("midrst_rden", 32'({a_rden, b_rden}), 32'd0);
      chk("midrst_result_or", 32'(|result), 32'd0);
      chk("midrst_b_left", 32'(b_wr - b_rd), 32'd2);
      chk("midrst_a0_left", 32'(a_wr[0] - a_rd[0]), 32'd2);
      chk("midrst_a7_left", 32'(a_wr[7] - a_rd[7]), 32'd8);
      rst = 1'b0;
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("midrst_no_done", 32'(pulses), 32'd0);

      // max operands
      load(1, -1, -1);
      for (int i = 0; i < ROWS; i++) exp_res[i] = 24'h7F008;
      do_run("max", 8'hFF, 1'b0);

      // identity
      load(2, -1, -1);
      for (int i = 0; i < ROWS; i++) exp_res[i] = 24'(24'h11 + i);
      do_run("ident", 8'hFF, 1'b0);

      // start with row 3 empty is ignored
      load(2, -1, 3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      saw_busy = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      chk("empty3_busy", 32'(saw_busy), 32'd0);
      chk("empty3_res2_kept", 32'(result[2*ACCW +: ACCW]), 32'h13);

      // row 5 short by one entry -> underflow flagged, run still completes
      load(0, 5, -1);
      for (int i = 0; i < ROWS; i++) exp_res[i] = 24'h24;
      do_run("short5", 8'hDF, 1'b1);
      repeat (3) @(negedge clk);
      chk("short5_err_sticky", 32'(err), 32'd1);

      // next accepted start clears err
      load(0, -1, -1);
      do_run("clear", 8'hFF, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/matvec_engine.md
# matvec_engine

Downstream consumer of the FIFO fill stage. It drains eight row FIFOs (matrix A, ROWS×COLS bytes) and one vector FIFO (B, COLS bytes), streams the operands through a skewed (systolic) array of ROWS multiply-accumulate lanes, and presents ROWS dot-product results with a one-cycle done pulse. It sits between the nine FIFO instances and the result writeback/host logic.

## Interface
- ROWS, 8, number of A row FIFOs and MAC lanes
- COLS, 8, elements per row and per vector (entries drained from each FIFO per run)
- DW, 8, operand width (unsigned)
- ACCW, 24, accumulator/result width per lane
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin one matrix-vector run
- a_data  in  ROWS*DW  FIFO o_data of row FIFOs; lane i at bits [i*DW +: DW]
- a_empty  in  ROWS  empty flags of row FIFOs
- a_rden  out  ROWS  read enables of row FIFOs
- b_data  in  DW  FIFO o_data of vector FIFO
- b_empty  in  1  empty flag of vector FIFO
- b_rden  out  1  read enable of vector FIFO
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse when all results are final
- err  out  1  sticky underflow flag
- result  out  ROWS*ACCW  lane i dot product at bits [i*ACCW +: ACCW]

## Operation
- FIFO read latency: o_data is valid the cycle after the cycle in which rden is high.
- States: IDLE, RUN, DONE. Cycle counter cyc, width enough for COLS+ROWS.
- IDLE: start=1 with all a_empty=0 and b_empty=0 → RUN, cyc←0, all accumulators←0, err←0. start while any FIFO is empty is ignored (stay IDLE, results unchanged).
- RUN, cycle cyc (0-based from the first RUN cycle):
  - b_rden=1 for cyc in [0, COLS-1].
  - a_rden[i]=1 for cyc in [i, i+COLS-1]; skew of one cycle per lane.
  - b_pipe[0]=b_data (combinational); b_pipe[i] is b_pipe[i-1] registered, so vector element k reaches lane i during cycle k+1+i.
  - Lane i accumulates acc[i] += a_data[i]*b_pipe[i] at the end of cycles i+1 … i+COLS. This is exactly COLS products per lane, and no accumulation occurs outside that window.
  - After the last accumulation of lane ROWS-1 (end of cycle ROWS+COLS-1, i.e. 15 at defaults) → DONE.
- DONE: done=1 for one cycle → IDLE.
- Arithmetic: unsigned DW×DW → 2·DW product, zero-extended to ACCW. Sums wrap modulo 2^ACCW, which cannot occur at defaults (max 0x7F008).
- result is driven directly from the accumulators. It is stable from done until the next accepted start, which clears it.
- err: set if any rden is asserted while its corresponding empty flag is high. It stays set until rst or the next accepted start. The run continues regardless, and the garbage data is accumulated.
- start during RUN or DONE is ignored.

## Timing
- Reset (rst=1 at a rising edge): state=IDLE, cyc=0, busy=0, done=0, err=0, a_rden=0, b_rden=0, result=0, b_pipe=0. Reset mid-run aborts immediately with no done pulse.
- Start accepted at edge T → busy=1 and b_rden=a_rden[0]=1 in the cycle after T.
- busy is high for ROWS+COLS cycles (16 at defaults). done is high in the following cycle, with busy=0.
- Start-to-done latency is ROWS+COLS+1 cycles (17 at defaults). Back-to-back: a start asserted in the cycle after done is accepted.
- Each FIFO sees exactly COLS rden cycles per run, all contiguous.

## Test plan
- Reset mid-run: assert start, then rst at cyc=5 → all outputs zero next cycle, no done pulse. FIFOs keep their remaining entries.
- Ones × ramp: A all 0x01, B = 0x01..0x08 → every result = 36 (0x24). done is seen exactly 17 cycles after the start edge, and busy is high for 16 cycles.
- Max operands: all A and B bytes 0xFF → every result = 0x7F008, confirming no overflow or truncation.
- Identity: row i holds 0x01 at column i and 0x00 elsewhere, B = 0x11..0x18 → result[i] = 0x11+i. This checks the skew alignment per lane.
- Rden pattern: monitor a_rden[i], which must be high exactly during cycles i..i+7 after acceptance. b_rden must be high during cycles 0..7. Each FIFO must end empty after the run.
- Empty handling:
  - start with a_empty[3]=1 → ignored, busy stays 0.
  - Row 5 FIFO preloaded with only 7 entries and start accepted → err=1 after its 8th read. done still pulses, and err stays set until the next accepted start.
